imem_fetch_port: RTL and testbench

Parametrised instruction memory for the RISC-V core, with a valid/ready fetch port and a synchronous program-load port.
- Replaces the reset-triggered, hard-coded, combinational-read instruction store.
- Storage is DEPTH words of XLEN bits at byte base address BASE_ADDR.
- Adds registered reads, alignment and range fault reporting, byte-enabled loading, and a post-reset clear sequence.

---
 rtl/imem_fetch_port.sv | 121 ++++++++++++
 tb/tb_imem_fetch_port.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_port.sv
// Instruction memory for the RISC-V core: registered valid/ready fetch port,
// byte-enabled program-load port and a NOP-fill clear sequence after reset.
module imem_fetch_port #(
   parameter int              XLEN           = 32,
   parameter int              DEPTH          = 64,
   parameter logic [XLEN-1:0] BASE_ADDR      = '0,
   parameter logic [31:0]     NOP_WORD       = 32'h00000013,
   parameter bit              CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   output logic              busy,
   input  logic              load_en,
   input  logic [XLEN-1:0]   load_addr,
   input  logic [XLEN-1:0]   load_data,
   input  logic [XLEN/8-1:0] load_be,
   output logic              load_err,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [XLEN-1:0]   req_pc,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_instr,
   output logic [XLEN-1:0]   resp_pc,
   output logic [1:0]        resp_fault
);

   localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              NBYTES   = XLEN / 8;
   localparam logic [XLEN-1:0] SPAN     = XLEN'(DEPTH * 4);
   localparam logic [XLEN-1:0] NOP_FILL = XLEN'(NOP_WORD);

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] READY = 1'b1;

   localparam logic [1:0] FAULT_OK    = 2'b00;
   localparam logic [1:0] FAULT_ALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE = 2'b10;

   logic [XLEN-1:0]  mem [DEPTH];
   logic [0:0]       state;
   logic [IDX_W-1:0] clear_idx;
   logic [1:0]       req_fault;
   logic [1:0]       load_fault;
   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] load_idx;
   logic             accept;
   logic             load_ok;

   // Misalignment outranks the range check; addresses below the base fault
   // explicitly because the wrapped offset alone would not catch every case.
   function automatic logic [1:0] decode_fault(input logic [XLEN-1:0] addr);
      if (addr[1:0] != 2'b00) return FAULT_ALIGN;
      if ((addr < BASE_ADDR) || ((addr - BASE_ADDR) >= SPAN)) return FAULT_RANGE;
      return FAULT_OK;
   endfunction

   function automatic logic [IDX_W-1:0] decode_index(input logic [XLEN-1:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   always_comb begin
      req_fault  = decode_fault(req_pc);
      load_fault = decode_fault(load_addr);
      req_idx    = decode_index(req_pc);
      load_idx   = decode_index(load_addr);
   end

   assign busy      = (state == CLEAR);
   assign req_ready = (state == READY) && (!resp_valid || resp_ready);
   assign accept    = req_valid && req_ready;
   assign load_ok   = (state == READY) && load_en && (load_fault == FAULT_OK);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= CLEAR_ON_RESET ? CLEAR : READY;
         clear_idx  <= '0;
         resp_valid <= 1'b0;
         resp_instr <= '0;
         resp_pc    <= '0;
         resp_fault <= FAULT_OK;
         load_err   <= 1'b0;
      end else begin
         if (state == CLEAR) begin
            if (clear_idx == IDX_W'(DEPTH - 1)) begin
               state <= READY;
            end else begin
               clear_idx <= clear_idx + 1'b1;
            end
         end

         load_err <= (state == READY) && load_en && (load_fault != FAULT_OK);

         if (accept) begin
            resp_valid <= 1'b1;
            resp_pc    <= req_pc;
            resp_fault <= req_fault;
            resp_instr <= (req_fault == FAULT_OK) ? mem[req_idx] : '0;
         end else if (resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end

   // Storage has no reset so contents survive reset when the clear is disabled;
   // the read above sees the pre-edge word, giving read-before-write on collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[clear_idx] <= NOP_FILL;
         end else if (load_ok) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (load_be[b]) begin
                  mem[load_idx][8*b +: 8] <= load_data[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Randomised self-checking bench for imem_fetch_port against a behavioural
// word-array model, plus a small offset-base instance for range decoding.
module tb_imem_fetch_port;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk;
   logic        reset;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic [3:0]  load_be;
   logic        req_valid;
   logic [31:0] req_pc;
   logic        resp_ready;

   logic        busy, load_err, req_ready, resp_valid;
   logic [31:0] resp_instr, resp_pc;
   logic [1:0]  resp_fault;

   logic        b_busy, b_load_err, b_req_ready, b_resp_valid;
   logic [31:0] b_resp_instr, b_resp_pc;
   logic [1:0]  b_resp_fault;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_mem [DEPTH];
   int          m_clear = 0;
   bit          m_rv = 0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc = '0;
   logic [1:0]  m_fault = '0;
   bit          m_lerr = 0;
   bit          model_live = 0;

   imem_fetch_port #(
      .XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .NOP_WORD(NOP), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .busy(busy),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_be(load_be),
      .load_err(load_err),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
      .resp_pc(resp_pc), .resp_fault(resp_fault)
   );

   imem_fetch_port #(
      .XLEN(32), .DEPTH(5), .BASE_ADDR(32'h1000), .NOP_WORD(NOP), .CLEAR_ON_RESET(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .busy(b_busy),
      .load_en(1'b0), .load_addr(32'h0), .load_data(32'h0), .load_be(4'h0),
      .load_err(b_load_err),
      .req_valid(req_valid), .req_ready(b_req_ready), .req_pc(req_pc),
      .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_instr(b_resp_instr),
      .resp_pc(b_resp_pc), .resp_fault(b_resp_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] faultOf(input logic [31:0] a);
      if (a % 4 != 0) return 2'd1;
      if (longint'(a) < longint'(BASE) || longint'(a) - longint'(BASE) >= longint'(DEPTH) * 4)
         return 2'd2;
      return 2'd0;
   endfunction

   function automatic int indexOf(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   // Advance the model by one clock edge using the inputs that were sampled.
   task automatic modelStep();
      logic [1:0] f;
      logic [1:0] lf;
      bit         acc;
      if (reset) begin
         m_rv = 0; m_instr = '0; m_pc = '0; m_fault = '0; m_lerr = 0;
         m_clear = DEPTH;
         model_live = 1;
      end else if (m_clear > 0) begin
         m_mem[DEPTH - m_clear] = NOP;
         m_clear--;
         m_lerr = 0;
      end else begin
         acc = req_valid && (!m_rv || resp_ready);
         f = faultOf(req_pc);
         if (acc) begin
            m_rv = 1; m_pc = req_pc; m_fault = f;
            m_instr = (f == 2'd0) ? m_mem[indexOf(req_pc)] : 32'h0;
         end else if (resp_ready) begin
            m_rv = 0;
         end
         lf = faultOf(load_addr);
         m_lerr = load_en && (lf != 2'd0);
         if (load_en && lf == 2'd0) begin
            for (int b = 0; b < 4; b++)
               if (load_be[b]) m_mem[indexOf(load_addr)][8*b +: 8] = load_data[8*b +: 8];
         end
      end
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      if (model_live) begin
         checkOutput("busy", 32'(busy), 32'(m_clear > 0));
         checkOutput("req_ready", 32'(req_ready), 32'((m_clear == 0) && (!m_rv || resp_ready)));
         checkOutput("resp_valid", 32'(resp_valid), 32'(m_rv));
         checkOutput("resp_instr", resp_instr, m_instr);
         checkOutput("resp_pc", resp_pc, m_pc);
         checkOutput("resp_fault", 32'(resp_fault), 32'(m_fault));
         checkOutput("load_err", 32'(load_err), 32'(m_lerr));
      end
      @(posedge clk);
      #1;
      modelStep();
   endtask

   task automatic setIdle();
      req_valid = 0; req_pc = '0; resp_ready = 1;
      load_en = 0; load_addr = '0; load_data = '0; load_be = '0;
   endtask

   task automatic doFetch(input logic [31:0] pc);
      setIdle();
      req_valid = 1; req_pc = pc;
      applyStimulus();
   endtask

   task automatic doLoad(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      setIdle();
      load_en = 1; load_addr = a; load_data = d; load_be = be;
      applyStimulus();
   endtask

   function automatic logic [31:0] randAddr();
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      if (kind <= 6) a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (kind == 7) a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1) | 1);
      else if (kind == 8) a = BASE + 32'(DEPTH * 4 + $urandom_range(0, 15) * 4);
      else a = $urandom;
      return a;
   endfunction

   task automatic checkB(input logic [31:0] pc, input logic [31:0] instr, input logic [1:0] f);
      doFetch(pc);
      checkOutput("b_busy", 32'(b_busy), 32'h0);
      checkOutput("b_load_err", 32'(b_load_err), 32'h0);
      checkOutput("b_resp_valid", 32'(b_resp_valid), 32'h1);
      checkOutput("b_resp_pc", b_resp_pc, pc);
      checkOutput("b_resp_fault", 32'(b_resp_fault), 32'(f));
      checkOutput("b_resp_instr", b_resp_instr, instr);
   endtask

   initial begin
      setIdle();
      reset = 1;
      applyStimulus();
      reset = 0;
      repeat (DEPTH) applyStimulus();

      doFetch(32'h0); doFetch(32'h4); doFetch(32'hFC);
      setIdle(); applyStimulus();

      doLoad(32'h0, 32'h00002083, 4'hF);
      doLoad(32'h4, 32'h00402103, 4'hF);
      doLoad(32'hC, 32'h022080B3, 4'hF);
      doFetch(32'h0); doFetch(32'h4); doFetch(32'hC);
      doLoad(32'hC, 32'hFFFFFFAA, 4'h1);
      doFetch(32'hC);
      doLoad(32'h8, 32'h12345678, 4'h0);
      doFetch(32'h2); doFetch(32'h100);
      doLoad(32'h101, 32'hCAFEF00D, 4'hF);
      doFetch(32'h0); doFetch(32'h8);
      setIdle(); applyStimulus();

      // Backpressure: pending request must wait until the consumer drains.
      doFetch(32'h4);
      req_valid = 1; req_pc = 32'h8; resp_ready = 0;
      repeat (3) applyStimulus();
      resp_ready = 1;
      applyStimulus();
      setIdle(); applyStimulus();

      // Same-cycle load and fetch of one word returns the old contents.
      setIdle();
      load_en = 1; load_addr = 32'h8; load_data = 32'hDEADBEEF; load_be = 4'hF;
      req_valid = 1; req_pc = 32'h8;
      applyStimulus();
      doFetch(32'h8);
      setIdle(); applyStimulus();

      for (int i = 0; i < 800; i++) begin
         req_valid  = ($urandom_range(0, 3) != 0);
         req_pc     = randAddr();
         resp_ready = ($urandom_range(0, 3) != 0);
         load_en    = ($urandom_range(0, 3) == 0);
         load_addr  = randAddr();
         load_data  = $urandom;
         load_be    = 4'($urandom);
         applyStimulus();
      end

      // Reset while a response is held, then again partway through the clear.
      setIdle(); applyStimulus();
      setIdle(); req_valid = 1; req_pc = 32'h4; resp_ready = 0;
      applyStimulus();
      setIdle(); resp_ready = 0; reset = 1;
      applyStimulus();
      reset = 0;
      repeat (20) applyStimulus();
      reset = 1; applyStimulus(); reset = 0;
      for (int i = 0; i < DEPTH + 2 && m_clear > 0; i++) applyStimulus();
      doFetch(32'h0); doFetch(32'hC); doFetch(32'hFC);
      setIdle(); applyStimulus();

      checkB(32'h00000FFC, 32'h0, 2'd2);
      checkB(32'h00001000, NOP, 2'd0);
      checkB(32'h00001010, NOP, 2'd0);
      checkB(32'h00001014, 32'h0, 2'd2);
      checkB(32'h00001006, 32'h0, 2'd1);
      setIdle(); applyStimulus();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
